// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
// hilo_muldiv_unit : multi-cycle MULT/MULTU/DIV/DIVU engine feeding HI/LO
// Revision 1.0
// ============================================================================
`default_nettype none

module hilo_muldiv_unit #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic        hilo_write_en_o,
    output logic [31:0] hi_write_data_o,
    output logic [31:0] lo_write_data_o
);

    localparam logic [3:0] MUL_LAST = 4'(MUL_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q;
    logic        signed_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] divisor_q;
    logic        neg_a_q;
    logic        neg_b_q;
    logic        div_zero_q;
    logic [3:0]  cnt_mul_q;
    logic [4:0]  cnt_div_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        neg_a_d;
    logic        neg_b_d;
    logic [31:0] mag_a_d;
    logic [31:0] mag_b_d;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic [32:0] div_partial;
    logic [32:0] div_trial;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        neg_a_d = ~op_i[0] & src_a_i[31];
        neg_b_d = ~op_i[0] & src_b_i[31];
        mag_a_d = neg_a_d ? (~src_a_i + 32'd1) : src_a_i;
        mag_b_d = neg_b_d ? (~src_b_i + 32'd1) : src_b_i;
    end

    // Low 64 bits of the product of the extended operands give both the
    // signed and the unsigned result, so a single multiplier serves both.
    always_comb begin
        a_ext   = {{32{signed_q & a_q[31]}}, a_q};
        b_ext   = {{32{signed_q & b_q[31]}}, b_q};
        product = a_ext * b_ext;
    end

    always_comb begin
        div_partial = {rem_q, quo_q[31]};
        div_trial   = div_partial - {1'b0, divisor_q};
        if (!div_trial[32]) begin
            rem_d = div_trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end else begin
            rem_d = div_partial[31:0];
            quo_d = {quo_q[30:0], 1'b0};
        end
        quo_fix = (neg_a_q ^ neg_b_q) ? (~quo_q + 32'd1) : quo_q;
        rem_fix = neg_a_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            signed_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            cnt_mul_q  <= '0;
            cnt_div_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !cancel_i) begin
                        signed_q <= ~op_i[0];
                        a_q      <= src_a_i;
                        b_q      <= src_b_i;
                        busy_q   <= 1'b1;
                        if (op_i[1]) begin
                            state_q    <= S_DIV;
                            neg_a_q    <= neg_a_d;
                            neg_b_q    <= neg_b_d;
                            div_zero_q <= (src_b_i == 32'd0);
                            quo_q      <= mag_a_d;
                            divisor_q  <= mag_b_d;
                            rem_q      <= '0;
                            cnt_div_q  <= '0;
                        end else begin
                            state_q   <= S_MUL;
                            cnt_mul_q <= '0;
                        end
                    end
                end
                S_MUL: begin
                    if (cancel_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_mul_q == MUL_LAST) begin
                        state_q <= S_DONE;
                        hi_q    <= product[63:32];
                        lo_q    <= product[31:0];
                        done_q  <= 1'b1;
                    end else begin
                        cnt_mul_q <= cnt_mul_q + 4'd1;
                    end
                end
                S_DIV: begin
                    if (cancel_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q     <= rem_d;
                        quo_q     <= quo_d;
                        cnt_div_q <= cnt_div_q + 5'd1;
                        // 32nd iteration: the counter wraps to zero here
                        if (cnt_div_q == 5'd31) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (cancel_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        if (div_zero_q) begin
                            hi_q <= a_q;
                            lo_q <= 32'hFFFF_FFFF;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign hilo_write_en_o = done_q & ~cancel_i;
    assign hi_write_data_o = hi_q;
    assign lo_write_data_o = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// ============================================================================
// tb_hilo_muldiv_unit : scoreboard bench for hilo_muldiv_unit
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_unit;

    localparam int MUL_L = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    hilo_muldiv_unit #(.MUL_LATENCY(MUL_L)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .op_i            (op),
        .src_a_i         (src_a),
        .src_b_i         (src_b),
        .cancel_i        (cancel),
        .busy_o          (busy),
        .hilo_write_en_o (we),
        .hi_write_data_o (hi),
        .lo_write_data_o (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && we) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got hi=%h lo=%h at cycle %0d, required no write",
                         hi, lo, cyc);
            end else begin
                e = sb.pop_front();
                check32({e.name, "_hi"}, hi, e.hi);
                check32({e.name, "_lo"}, lo, e.lo);
                check_int({e.name, "_pulse_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int e);
        @(negedge clk);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e     = cyc;
    endtask

    task automatic wait_idle(input string nm, input int e, input int len);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        check_int({nm, "_busy_len"}, cyc - e, len);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int   e;
        exp_t x;
        issue(o, a, b, e);
        check32({nm, "_busy_at_accept"}, {31'b0, busy}, 32'd1);
        x.hi   = ehi;
        x.lo   = elo;
        x.cyc  = e + (o[1] ? 33 : MUL_L + 1);
        x.name = nm;
        sb.push_back(x);
        wait_idle(nm, e, o[1] ? 34 : MUL_L + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e;
        exp_t x;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        src_a  = '0;
        src_b  = '0;
        cancel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_busy", {31'b0, busy}, 32'd0);
        check32("reset_we",   {31'b0, we},   32'd0);
        check32("reset_hi",   hi, 32'd0);
        check32("reset_lo",   lo, 32'd0);
        rst_n = 1'b1;

        run_op("mult_neg",   2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7_2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2",   2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_100_7", 2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
        run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_5_0",   2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_op("div_m8_0",   2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF);

        // Cancel a divide at its tenth edge: no write, data regs keep last result.
        issue(2'b10, 32'd1000, 32'd3, e);
        wait_until(e + 9);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check32("cancel_div_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check32("cancel_div_hi", hi, 32'hFFFF_FFF8);
        check32("cancel_div_lo", lo, 32'hFFFF_FFFF);

        // Cancel during DONE: the pulse must be suppressed.
        issue(2'b00, 32'd2, 32'd3, e);
        wait_until(e + MUL_L + 1);
        cancel = 1'b1;
        #1;
        check32("cancel_done_we", {31'b0, we}, 32'd0);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check32("cancel_done_busy", {31'b0, busy}, 32'd0);
        repeat (5) @(negedge clk);

        // start held high: operands change while busy, second op only after IDLE.
        issue(2'b00, 32'd3, 32'd5, e);
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'd7;
        src_b = 32'd9;
        x.hi = 32'd0; x.lo = 32'd15; x.cyc = e + MUL_L + 1; x.name = "held_first";
        sb.push_back(x);
        x.hi = 32'd0; x.lo = 32'd63; x.cyc = e + 2 * MUL_L + 4; x.name = "held_second";
        sb.push_back(x);
        wait_until(e + MUL_L + 2);
        check32("held_idle_gap", {31'b0, busy}, 32'd0);
        wait_until(e + MUL_L + 3);
        start = 1'b0;
        check32("held_reaccept", {31'b0, busy}, 32'd1);
        wait_idle("held", e, 2 * MUL_L + 5);

        // Asynchronous reset in the middle of a divide.
        issue(2'b10, 32'd12345, 32'd11, e);
        wait_until(e + 10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("rst_mid_busy", {31'b0, busy}, 32'd0);
        check32("rst_mid_we",   {31'b0, we},   32'd0);
        check32("rst_mid_hi",   hi, 32'd0);
        check32("rst_mid_lo",   lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check32("rst_after_busy", {31'b0, busy}, 32'd0);
        check32("rst_after_hi",   hi, 32'd0);

        check_int("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle multiply/divide engine that produces the write side of the CPU's HI/LO register pair. It sits in the execute stage alongside the ALU and accepts MULT/MULTU/DIV/DIVU operands. It stalls the pipeline via `busy` while working, then emits a one-cycle HI/LO write (`hilo_write_en`, `hi_write_data`, `lo_write_data`). That write feeds the HI/LO register file and the HI/LO forwarding path.

## Interface
- `MUL_LATENCY`, default 2: number of pipeline wait cycles between operand capture and multiply result; legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `src_a`  in  32  multiplicand / dividend.
- `src_b`  in  32  multiplier / divisor.
- `cancel`  in  1  pipeline flush; aborts any operation in progress.
- `busy`  out  1  high while an accepted operation is unfinished, including the DONE cycle.
- `hilo_write_en`  out  1  one-cycle pulse; HI/LO write valid.
- `hi_write_data`  out  32  MULT: product[63:32]; DIV: remainder.
- `lo_write_data`  out  32  MULT: product[31:0]; DIV: quotient.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Reset (asynchronous): state IDLE; `busy`=0, `hilo_write_en`=0, `hi_write_data`=0, `lo_write_data`=0; counters cleared.
- IDLE, with `start`=1 and `cancel`=0: latch `op`, `src_a`, `src_b`.
  - Multiply goes to MUL.
  - Divide goes to DIV. It latches magnitudes when signed, the signs of a and b, and a zero-divisor flag.
  - `start` outside IDLE is ignored. No queueing.
- MUL:
  - Signed: 64-bit two's-complement product. Unsigned: zero-extended product.
  - Counter runs 1..`MUL_LATENCY`, then goes to DONE with the product registered into the output data regs.
- DIV: restoring division on 32-bit magnitudes, one quotient bit per cycle, 32 iterations (5-bit counter; the wrap to 0 ends the phase), then FIX.
- FIX: sign correction for DIV.
  - Quotient is negated if sign(a)≠sign(b). Remainder is negated if a<0.
  - DIVU passes results through unchanged.
  - Result is registered into the data regs; next state DONE.
- Boundary results:
  - Divisor 0 (DIV or DIVU): HI=`src_a`, LO=32'hFFFF_FFFF. Same 34-cycle timing, no sign fixup.
  - DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0 (no trap).
- DONE: `hilo_write_en`=1 for exactly this cycle; next state IDLE.
- `cancel`: highest priority, synchronous.
  - In MUL/DIV/FIX: next state IDLE; no write occurs; data regs unchanged.
  - In DONE: `hilo_write_en` is gated low combinationally (`done & ~cancel`).
  - In IDLE: suppresses acceptance of a same-cycle `start`.
- `hi_write_data`/`lo_write_data` hold their last value outside DONE.

## Timing
- Acceptance edge = edge 0.
- Multiply: `hilo_write_en` high after edge `MUL_LATENCY`+1 (default: edge 3), low after edge `MUL_LATENCY`+2.
- Divide: iterations on edges 1..32, FIX on edge 33, `hilo_write_en` high from edge 33 to edge 34.
- `busy` goes high at edge 0 and low at the edge leaving DONE. `busy` is never high in IDLE.
- Back-to-back operation: a new `start` is accepted in the first IDLE cycle after DONE, i.e. the earliest re-accept edge is the one after `busy` falls. There is no zero-bubble chaining.
- Reset asserted mid-operation: all outputs return to reset values immediately, with no write pulse.

## Test plan
- After reset: `busy`=0, `hilo_write_en`=0, HI=LO=0. MULT 0xFFFF_FFFE × 0x0000_0003 at edge 0 -> pulse at edge 3; HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; `busy` high edges 0..4.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV -7 / 2 -> pulse after edge 33 only; LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 100 / 7 -> LO=14, HI=2.
- Boundaries:
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
  - DIVU 5 / 0 -> LO=0xFFFF_FFFF, HI=5.
- `cancel` at edge 10 of a DIV -> IDLE next edge, no pulse, data regs unchanged. `cancel` during DONE -> `hilo_write_en` stays 0.
- `start` held high during busy -> ignored; a second op is accepted only after IDLE is reached. `rst_n` low mid-DIV -> outputs zero asynchronously, no pulse after release.
